// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of the UART receiver: FIFO pop handshake, FIFO status,
// frame-in-progress indication and the sticky error flags with their clear.
//   slave  : the receiver (drives data/status, samples rd_en/err_clr)
//   master : the consumer (IOBUS peripheral decoder or testbench)
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_W    = 4
);
  logic                 rd_en;
  logic                 err_clr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 empty;
  logic                 full;
  logic [ADDR_W:0]      count;
  logic                 busy;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport slave (
    input  rd_en, err_clr,
    output rd_data, empty, full, count, busy, parity_err, frame_err, overrun
  );

  modport master (
    output rd_en, err_clr,
    input  rd_data, empty, full, count, busy, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled majority-vote bit recovery, configurable
// data width / parity / stop bits, a first-word-fall-through RX FIFO and
// sticky error flags.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   rx     serial input, idle high, asynchronous to clk
//   bus    uart_rx_fifo_if.slave: rd_en, rd_data, empty, full, count, busy,
//          parity_err, frame_err, overrun, err_clr
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | start bit; a voted 1 is treated as a glitch
// DATA  | shifting payload bits in, LSB first
// PAR   | parity bit, mismatch is recorded
// STOP  | stop bit(s); push happens at the final stop-bit vote
// BRK   | stop bit was low; waiting for the line to return high
module uart_rx_fifo #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  uart_rx_fifo_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS + 1);
  localparam int MID   = OVERSAMPLE / 2;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  logic rx_meta_q, rx_s_q, rx_prev_q;
  state_t state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BC_W-1:0]      bit_q, bit_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 busy_q, busy_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic tick, start_edge, decide, bit_end, vote, exp_par;
  logic push, pop, push_ok, full, empty, par_evt, frame_evt;

  assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
  assign start_edge = rx_prev_q & ~rx_s_q;
  assign decide     = tick && (os_q == OS_W'(MID + 1));
  assign bit_end    = tick && (os_q == OS_W'(OVERSAMPLE - 1));
  // Third sample is the live value at the decision tick.
  assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
  assign exp_par    = (PARITY == 1) ? ~^shift_q : ^shift_q;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop     = bus.rd_en & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push & (~full | pop);

  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + 1'b1;
    os_d       = os_q;
    bit_d      = bit_q;
    stop_idx_d = stop_idx_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    push       = 1'b0;
    par_evt    = 1'b0;
    frame_evt  = 1'b0;

    if (tick) begin
      os_d = bit_end ? '0 : os_q + 1'b1;
      if (os_q == OS_W'(MID - 1)) smp_d[0] = rx_s_q;
      if (os_q == OS_W'(MID))     smp_d[1] = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        os_d       = '0;
        bit_d      = '0;
        stop_idx_d = 1'b0;
        par_bad_d  = 1'b0;
        if (start_edge) begin
          state_d = START;
          div_d   = '0;
        end
      end
      START: begin
        if (decide && vote) state_d = IDLE;
        else if (bit_end)   state_d = DATA;
      end
      DATA: begin
        if (decide) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
        end
        if (bit_end && bit_q == BC_W'(DATA_BITS))
          state_d = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (decide) begin
          par_bad_d = (vote != exp_par);
          par_evt   = (vote != exp_par);
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (decide) begin
          if (!vote) begin
            frame_evt = 1'b1;
            state_d   = BRK;
          end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            push    = ~par_bad_q;
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      BRK:     if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    parity_err_d = (parity_err_q & ~bus.err_clr) | par_evt;
    frame_err_d  = (frame_err_q & ~bus.err_clr) | frame_evt;
    overrun_d    = (overrun_q & ~bus.err_clr) | (push & ~push_ok);

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      div_q        <= '0;
      os_q         <= '0;
      bit_q        <= '0;
      stop_idx_q   <= 1'b0;
      smp_q        <= 2'b11;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      div_q        <= div_d;
      os_q         <= os_d;
      bit_q        <= bit_d;
      stop_idx_q   <= stop_idx_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      busy_q       <= busy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: rd_data is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign bus.rd_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int BIT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .ADDR_W(4)) b0();
  uart_rx_fifo_if #(.DATA_BITS(8), .ADDR_W(4)) b1();

  uart_rx_fifo #(.PARITY(0)) dut0 (.clk(clk), .rst_n(rst_n), .rx(rx0), .bus(b0));
  uart_rx_fifo #(.PARITY(2)) dut1 (.clk(clk), .rst_n(rst_n), .rx(rx1), .bus(b1));

  task automatic drive_bit(input int line, input logic v, input int cycles);
    if (line == 0) rx0 = v;
    else rx1 = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_head(input int line, input logic [7:0] d, input bit use_par, input logic par);
    drive_bit(line, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(line, d[i], BIT);
    if (use_par) drive_bit(line, par, BIT);
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input bit use_par, input logic par);
    send_head(line, d, use_par, par);
    drive_bit(line, 1'b1, BIT);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    if ({b0.empty, b0.full, b0.count, b0.busy, b0.parity_err, b0.frame_err, b0.overrun, b0.rd_data} !== {1'b1, 1'b0, 5'd0, 4'b0000, 8'h00}) begin
      $display("FAIL reset_dut0 got e=%b f=%b c=%0d b=%b pe=%b fe=%b ov=%b d=%h", b0.empty, b0.full, b0.count, b0.busy, b0.parity_err, b0.frame_err, b0.overrun, b0.rd_data);
      n_errors++;
    end
    n_checks++;
    if ({b1.empty, b1.full, b1.count, b1.busy, b1.parity_err, b1.frame_err, b1.overrun, b1.rd_data} !== {1'b1, 1'b0, 5'd0, 4'b0000, 8'h00}) begin
      $display("FAIL reset_dut1 got e=%b c=%0d b=%b d=%h", b1.empty, b1.count, b1.busy, b1.rd_data);
      n_errors++;
    end
    n_checks++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    send_frame(0, 8'h55, 0, 1'b0);
    q0.push_back(8'h55);
    if (b0.empty !== 1'b0 || b0.count !== 5'd1) begin
      $display("FAIL basic_status got empty=%b count=%0d want 0/1", b0.empty, b0.count);
      n_errors++;
    end
    n_checks++;
    exp_b = q0.pop_front();
    if (b0.rd_data !== exp_b) begin
      $display("FAIL basic_data got %h want %h", b0.rd_data, exp_b);
      n_errors++;
    end
    n_checks++;
    b0.rd_en = 1'b1;
    @(negedge clk);
    b0.rd_en = 1'b0;
    if ({b0.empty, b0.count, b0.parity_err, b0.frame_err, b0.overrun} !== {1'b1, 5'd0, 3'b000}) begin
      $display("FAIL basic_pop got empty=%b count=%0d flags=%b%b%b", b0.empty, b0.count, b0.parity_err, b0.frame_err, b0.overrun);
      n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_glitch;
    drive_bit(0, 1'b0, 10);
    if (b0.busy !== 1'b1) begin
      $display("FAIL glitch_busy_on got %b want 1", b0.busy);
      n_errors++;
    end
    n_checks++;
    drive_bit(0, 1'b0, 10);
    drive_bit(0, 1'b1, 100);
    if ({b0.busy, b0.count, b0.parity_err, b0.frame_err, b0.overrun} !== {1'b0, 5'd0, 3'b000}) begin
      $display("FAIL glitch_idle got busy=%b count=%0d flags=%b%b%b", b0.busy, b0.count, b0.parity_err, b0.frame_err, b0.overrun);
      n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_parity;
    send_frame(1, 8'hA3, 1, 1'b1);
    if (b1.parity_err !== 1'b1 || b1.count !== 5'd0) begin
      $display("FAIL parity_bad got pe=%b count=%0d want 1/0", b1.parity_err, b1.count);
      n_errors++;
    end
    n_checks++;
    b1.err_clr = 1'b1;
    @(negedge clk);
    b1.err_clr = 1'b0;
    if (b1.parity_err !== 1'b0) begin
      $display("FAIL parity_clr got %b want 0", b1.parity_err);
      n_errors++;
    end
    n_checks++;
    send_frame(1, 8'hA3, 1, 1'b0);
    q1.push_back(8'hA3);
    exp_b = q1.pop_front();
    if (b1.rd_data !== exp_b || b1.count !== 5'd1 || b1.parity_err !== 1'b0) begin
      $display("FAIL parity_good got d=%h count=%0d pe=%b want %h/1/0", b1.rd_data, b1.count, b1.parity_err, exp_b);
      n_errors++;
    end
    n_checks++;
    b1.rd_en = 1'b1;
    @(negedge clk);
    b1.rd_en = 1'b0;
  endtask

  task automatic test_frame;
    send_head(0, 8'h3C, 0, 1'b0);
    drive_bit(0, 1'b0, 3 * BIT);
    if ({b0.frame_err, b0.busy, b0.empty} !== 3'b111) begin
      $display("FAIL frame_brk got fe=%b busy=%b empty=%b want 1/1/1", b0.frame_err, b0.busy, b0.empty);
      n_errors++;
    end
    n_checks++;
    drive_bit(0, 1'b1, 6);
    if (b0.busy !== 1'b0) begin
      $display("FAIL frame_release got busy=%b want 0", b0.busy);
      n_errors++;
    end
    n_checks++;
    drive_bit(0, 1'b1, BIT);
    send_frame(0, 8'h81, 0, 1'b0);
    q0.push_back(8'h81);
    exp_b = q0.pop_front();
    if (b0.rd_data !== exp_b || b0.count !== 5'd1) begin
      $display("FAIL frame_next got d=%h count=%0d want %h/1", b0.rd_data, b0.count, exp_b);
      n_errors++;
    end
    n_checks++;
    b0.rd_en = 1'b1;
    b0.err_clr = 1'b1;
    @(negedge clk);
    b0.rd_en = 1'b0;
    b0.err_clr = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0] head;
    for (int i = 0; i < 17; i++) begin
      send_frame(0, i[7:0], 0, 1'b0);
      if (i < 16) q0.push_back(i[7:0]);
    end
    if ({b0.full, b0.count, b0.overrun} !== {1'b1, 5'd16, 1'b1}) begin
      $display("FAIL ovf_status got full=%b count=%0d ov=%b want 1/16/1", b0.full, b0.count, b0.overrun);
      n_errors++;
    end
    n_checks++;
    b0.err_clr = 1'b1;
    @(negedge clk);
    b0.err_clr = 1'b0;
    if (b0.overrun !== 1'b0) begin
      $display("FAIL ovf_clr got %b want 0", b0.overrun);
      n_errors++;
    end
    n_checks++;
    head = q0.pop_front();
    q0.push_back(8'h77);
    // Push of 8'h77 lands on the 619th rising edge after rx falls.
    fork
      send_frame(0, 8'h77, 0, 1'b0);
      begin
        repeat (618) @(posedge clk);
        @(negedge clk);
        if (b0.rd_data !== head || b0.count !== 5'd16) begin
          $display("FAIL ovf_head got d=%h count=%0d want %h/16", b0.rd_data, b0.count, head);
          n_errors++;
        end
        n_checks++;
        b0.rd_en = 1'b1;
        @(negedge clk);
        b0.rd_en = 1'b0;
      end
    join
    if ({b0.full, b0.count, b0.overrun} !== {1'b1, 5'd16, 1'b0}) begin
      $display("FAIL ovf_coincident got full=%b count=%0d ov=%b want 1/16/0", b0.full, b0.count, b0.overrun);
      n_errors++;
    end
    n_checks++;
    for (int i = 0; i < 16; i++) begin
      exp_b = q0.pop_front();
      if (b0.rd_data !== exp_b) begin
        $display("FAIL ovf_read%0d got %h want %h", i, b0.rd_data, exp_b);
        n_errors++;
      end
      n_checks++;
      b0.rd_en = 1'b1;
      @(negedge clk);
      b0.rd_en = 1'b0;
    end
    if (b0.empty !== 1'b1 || b0.count !== 5'd0) begin
      $display("FAIL ovf_drained got empty=%b count=%0d", b0.empty, b0.count);
      n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid;
    send_frame(0, 8'h11, 0, 1'b0);
    q0.push_back(8'h11);
    fork
      send_frame(0, 8'h7E, 0, 1'b0);
      begin
        repeat (4 * BIT) @(negedge clk);
        if (b0.busy !== 1'b1 || b0.count !== 5'd1) begin
          $display("FAIL rstmid_before got busy=%b count=%0d want 1/1", b0.busy, b0.count);
          n_errors++;
        end
        n_checks++;
        rst_n = 1'b0;
        @(negedge clk);
        if ({b0.empty, b0.full, b0.count, b0.busy, b0.parity_err, b0.frame_err, b0.overrun, b0.rd_data} !== {1'b1, 1'b0, 5'd0, 4'b0000, 8'h00}) begin
          $display("FAIL rstmid_state got e=%b c=%0d b=%b d=%h", b0.empty, b0.count, b0.busy, b0.rd_data);
          n_errors++;
        end
        n_checks++;
        q0.delete();
      end
    join
    rst_n = 1'b1;
    drive_bit(0, 1'b1, BIT);
    send_frame(0, 8'h42, 0, 1'b0);
    q0.push_back(8'h42);
    exp_b = q0.pop_front();
    if (b0.rd_data !== exp_b || b0.count !== 5'd1 || b0.frame_err !== 1'b0) begin
      $display("FAIL rstmid_after got d=%h count=%0d fe=%b want %h/1/0", b0.rd_data, b0.count, b0.frame_err, exp_b);
      n_errors++;
    end
    n_checks++;
  endtask

  initial begin
    b0.rd_en = 1'b0;
    b0.err_clr = 1'b0;
    b1.rd_en = 1'b0;
    b1.err_clr = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_frame();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with oversampled, majority-voted bit recovery. Supports configurable data width, parity mode and stop-bit count. Includes an integrated first-word-fall-through RX FIFO and sticky error flags. Sits between the board uart_rx pin and the IOBUS peripheral decoder, and replaces the fixed 8N1 single-byte receiver.

Parameters:
CLK_DIV, 4, clk cycles per oversample tick (>=1)
OVERSAMPLE, 16, ticks per bit (even, >=8)
DATA_BITS, 8, payload bits per frame (5..9)
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 16, FIFO entries (power of 2, >=2)
ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
rd_en  in  1  pop FIFO head (ignored when empty)
rd_data  out  DATA_BITS  FIFO head, valid while !empty
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  ADDR_W+1  entries held, 0..FIFO_DEPTH
busy  out  1  frame in progress (state != IDLE)
parity_err  out  1  sticky: parity mismatch seen
frame_err  out  1  sticky: a stop bit sampled low
overrun  out  1  sticky: byte received while FIFO full
err_clr  in  1  clears all three sticky flags

Behaviour:
- Decided interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: rd_data=0, empty=1, full=0, count=0, busy=0, all error flags 0. The rx synchroniser resets to 1 and FSM to IDLE. Reset mid-frame abandons the frame; no partial push.
- rx passes through a 2-flop synchroniser. All logic uses the synchronised rx_s.
- Tick generator: a counter 0..CLK_DIV-1 asserts tick for 1 clk at wrap. It free-runs but restarts at 0 on start detection.
- Bit timing: a tick counter 0..OVERSAMPLE-1 per bit.
- Bit value = majority of rx_s at ticks M-1, M, M+1, where M=OVERSAMPLE/2. The decision is taken at tick M+1.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: falling edge of rx_s -> START.
  - START: voted value 1 -> IDLE (false start, nothing recorded). Voted 0 -> DATA at end of bit.
  - DATA: shift LSB first, DATA_BITS bits. Then -> PAR if PARITY!=0, else -> STOP.
  - PAR: compare voted bit with computed parity. Odd: XOR(data)^1; even: XOR(data). Store the mismatch result.
  - STOP: STOP_BITS bits, each voted.
    - Any stop bit 0 -> set frame_err, discard byte, go to BRK.
    - All 1 -> push at the final stop-bit decision tick, then -> IDLE immediately. Rest of the stop bit is not waited for, so back-to-back frames are accepted.
  - BRK: wait until rx_s==1, then -> IDLE.
- Parity mismatch: set parity_err and discard the byte (no push), even if stop bits are good.
- Push when full: the byte is dropped, overrun is set, and FIFO contents are unchanged.
  - Exception: push and rd_en in the same cycle while full. Both succeed and count stays FIFO_DEPTH.
- Push and pop in the same cycle when non-empty and not full: count unchanged.
- FIFO is first-word-fall-through.
  - rd_data equals the head entry combinationally from registered storage and pointers.
  - After a push into an empty FIFO, empty deasserts and rd_data is valid on the next clk edge.
  - rd_en advances the head on the edge.
- Pointers are ADDR_W bits wide and wrap modulo FIFO_DEPTH. count is the separate ADDR_W+1 register. full = (count==FIFO_DEPTH); empty = (count==0).
- Sticky flags: err_clr clears them on the edge. A new error event in the same cycle as err_clr wins (flag = 1).
- busy = 1 in every state except IDLE, including BRK.
- Latency: the final stop-bit decision tick is ~(1 start + DATA_BITS + parity + STOP_BITS - 0.5) bit periods after the start edge, plus 2 clk of synchroniser delay. empty falls 1 clk after that tick.

Test Plan:
- Defaults, bit period 64 clk. Send 0x55 8N1 -> after stop, empty=0, count=1, rd_data=0x55. Pulse rd_en 1 clk -> empty=1, count=0, no error flags.
- PARITY=2. Send 0xA3 with parity bit 1 (correct is 0) -> parity_err=1, count=0. Then err_clr -> parity_err=0. Then send 0xA3 with parity 0 -> rd_data=0xA3.
- Send 0x3C with the stop bit held 0 for 3 bit periods, then idle -> frame_err=1, FIFO empty. FSM sits in BRK (busy=1) until rx high, then busy=0. A following 0x81 is received correctly.
- Glitch: rx low for 20 clk while IDLE -> false start, busy returns to 0, count=0, no flags set.
- Send 17 back-to-back bytes 0x00..0x10 without reading -> full=1, count=16, overrun=1. Reads return 0x00..0x0F in order; 0x10 is lost. A push coincident with rd_en while full keeps count=16.
- Assert rst_n=0 mid-DATA of byte 0x7E -> all outputs at reset values. After release, the next full frame 0x42 is received intact.
